// File: rtl/cpu_mem_host_arbiter_if.sv
// Host load/run port of cpu_mem_host_arbiter: transfer handshake plus run control/status.
// master = host side (drives requests), slave = arbiter side (drives ack/status).
interface cpu_mem_host_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 16,
    parameter int CW = 16
);
    logic          h_req;
    logic          h_we;
    logic          h_sel;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic          h_ack;
    logic [DW-1:0] h_rdata;
    logic          h_run;
    logic          busy;
    logic          done;
    logic [CW-1:0] run_cycles;

    modport master (
        output h_req, h_we, h_sel, h_addr, h_wdata, h_run,
        input  h_ack, h_rdata, busy, done, run_cycles
    );

    modport slave (
        input  h_req, h_we, h_sel, h_addr, h_wdata, h_run,
        output h_ack, h_rdata, busy, done, run_cycles
    );
endinterface

// File: rtl/cpu_mem_host_arbiter.sv
// cpu_mem_host_arbiter: hands I_MEMORY/D_MEMORY to the host while the CPU is idle,
// to the CPU during a run, and counts run cycles until the CPU halts.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   host (slave)      h_req/h_we/h_sel/h_addr/h_wdata -> h_ack/h_rdata,
//                     h_run -> busy/done/run_cycles
//   cpu_*             enable/start to the CPU, halt and memory bus from the CPU
//   im_*/dm_*         muxed address/write bus to the memories, read data back
//   timeout           watchdog expiry flag (only with CPU_MEM_WDT_EN)
// Build option: define CPU_MEM_WDT_EN to add the RUN watchdog and 'timeout'.
module cpu_mem_host_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int CW         = 16,
    parameter int WDT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          rst,
    cpu_mem_host_arbiter_if.slave host,
    output logic          cpu_enable,
    output logic          cpu_start,
    input  logic          cpu_halt,
    input  logic [AW-1:0] cpu_i_addr,
    input  logic [AW-1:0] cpu_d_addr,
    input  logic          cpu_d_we,
    input  logic [DW-1:0] cpu_d_dout,
    output logic [AW-1:0] im_addr,
    output logic          im_we,
    output logic [DW-1:0] im_din,
    output logic [AW-1:0] dm_addr,
    output logic          dm_we,
    output logic [DW-1:0] dm_din,
    input  logic [DW-1:0] im_dout,
    input  logic [DW-1:0] dm_dout
`ifdef CPU_MEM_WDT_EN
    ,
    output logic          timeout
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_XFER,
        S_START,
        S_RUN,
        S_HALTED
    } state_t;

    state_t state, state_nx;

    logic          l_sel;
    logic          l_we;
    logic          l_from_halted;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;

    logic          ack_q;
    logic [DW-1:0] rdata_q;
    logic          done_q;
    logic [CW-1:0] cycles_q;

    logic          accept_xfer;
    logic          accept_run;
    logic          wdt_hit;

`ifdef CPU_MEM_WDT_EN
    // Last RUN cycle before the count would reach the limit.
    assign wdt_hit = (cycles_q == CW'(WDT_CYCLES - 1));
`else
    assign wdt_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        accept_xfer = 1'b0;
        accept_run  = 1'b0;
        unique case (state)
            S_IDLE, S_HALTED: begin
                // Host transfers take priority over a pending run request.
                if (host.h_req) begin
                    accept_xfer = 1'b1;
                    state_nx    = S_XFER;
                end else if (host.h_run) begin
                    accept_run = 1'b1;
                    state_nx   = S_START;
                end
            end
            S_XFER:  state_nx = l_from_halted ? S_HALTED : S_IDLE;
            S_START: state_nx = S_RUN;
            S_RUN: begin
                if (cpu_halt || wdt_hit) state_nx = S_HALTED;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Control outputs decode the state directly so an async reset drops them at once.
    always_comb begin
        cpu_enable = (state == S_START) || (state == S_RUN);
        cpu_start  = (state == S_START);
    end

    // Memory muxes: host latch everywhere except RUN, writes only in XFER/RUN.
    always_comb begin
        im_addr = l_addr;
        dm_addr = l_addr;
        im_din  = l_wdata;
        dm_din  = l_wdata;
        im_we   = 1'b0;
        dm_we   = 1'b0;
        if (state == S_XFER) begin
            im_we = l_we & ~l_sel;
            dm_we = l_we & l_sel;
        end else if (state == S_RUN) begin
            im_addr = cpu_i_addr;
            dm_addr = cpu_d_addr;
            dm_we   = cpu_d_we;
            dm_din  = cpu_d_dout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_sel         <= 1'b0;
            l_we          <= 1'b0;
            l_from_halted <= 1'b0;
            l_addr        <= '0;
            l_wdata       <= '0;
            ack_q         <= 1'b0;
            rdata_q       <= '0;
            done_q        <= 1'b0;
            cycles_q      <= '0;
`ifdef CPU_MEM_WDT_EN
            timeout       <= 1'b0;
`endif
        end else begin
            ack_q <= (state == S_XFER);
            if (state == S_XFER && !l_we)
                rdata_q <= l_sel ? dm_dout : im_dout;
            if (accept_xfer) begin
                l_sel         <= host.h_sel;
                l_we          <= host.h_we;
                l_addr        <= host.h_addr;
                l_wdata       <= host.h_wdata;
                l_from_halted <= (state == S_HALTED);
            end
            if (accept_run) begin
                done_q   <= 1'b0;
                cycles_q <= '0;
`ifdef CPU_MEM_WDT_EN
                timeout  <= 1'b0;
`endif
            end
            if (state == S_RUN) begin
                if (cycles_q != '1)
                    cycles_q <= cycles_q + 1'b1;
                if (cpu_halt || wdt_hit)
                    done_q <= 1'b1;
`ifdef CPU_MEM_WDT_EN
                // A halt on the limit cycle is a normal finish.
                if (!cpu_halt && wdt_hit)
                    timeout <= 1'b1;
`endif
            end
        end
    end

    assign host.h_ack      = ack_q;
    assign host.h_rdata    = rdata_q;
    assign host.busy       = cpu_enable;
    assign host.done       = done_q;
    assign host.run_cycles = cycles_q;

endmodule
